// File: rtl/uart_bridge.sv
// UART-to-bus bridge: 8N1 serial commands drive single bus transactions.
// Ports: clk/reset, rx_in/tx_out serial, sel/read/mask/address/data bus.
//
// Command framing (little-endian fields):
//   write: 0x01, addr[4], mask[1], data[4]  -> response 0xA5
//   read : 0x02, addr[4]                    -> response data[4]
//
// Port summary:
//   clk             sole clock, rising edge
//   reset           asynchronous, active-high
//   rx_in           serial command input, idle high
//   tx_out          serial response output, idle high
//   sel_out         bus request, high only while a transaction is open
//   read_out        read strobe, valid with sel_out
//   write_mask_out  byte-write enables, valid with sel_out
//   address_out     bus byte address
//   write_value_out bus write data
//   read_value_in   bus read data, taken when ready_in is high
//   ready_in        completes the open transaction

module uart_bridge #(
    parameter logic [15:0] CLK_DIV = 16'd103
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_in,
    output logic        tx_out,
    output logic        sel_out,
    output logic        read_out,
    output logic [3:0]  write_mask_out,
    output logic [31:0] address_out,
    output logic [31:0] write_value_out,
    input  logic [31:0] read_value_in,
    input  logic        ready_in
);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic        rx_meta_q;
    logic        rx_sync_q;
    logic        rx_prev_q;
    logic [1:0]  rx_st_q,  rx_st_d;
    logic [15:0] rx_tmr_q, rx_tmr_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q,  rx_sh_d;
    logic        rx_valid;
    logic        rx_ferr;

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_tmr_d = rx_tmr_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: begin
                // Edge detect keeps a held-low line from retriggering.
                if (rx_prev_q && !rx_sync_q) begin
                    rx_st_d  = RX_START;
                    rx_tmr_d = CLK_DIV >> 1;
                end
            end
            RX_START: begin
                if (rx_tmr_q != 16'd0) begin
                    rx_tmr_d = rx_tmr_q - 16'd1;
                end else if (rx_sync_q) begin
                    rx_st_d = RX_IDLE;
                end else begin
                    rx_st_d  = RX_DATA;
                    rx_tmr_d = CLK_DIV;
                    rx_bit_d = 3'd0;
                end
            end
            RX_DATA: begin
                if (rx_tmr_q != 16'd0) begin
                    rx_tmr_d = rx_tmr_q - 16'd1;
                end else begin
                    rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                    rx_tmr_d = CLK_DIV;
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_tmr_q != 16'd0) begin
                    rx_tmr_d = rx_tmr_q - 16'd1;
                end else begin
                    rx_st_d  = RX_IDLE;
                    rx_valid = rx_sync_q;
                    rx_ferr  = !rx_sync_q;
                end
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= RX_IDLE;
            rx_tmr_q  <= 16'd0;
            rx_bit_q  <= 3'd0;
            rx_sh_q   <= 8'd0;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rx_st_q   <= rx_st_d;
            rx_tmr_q  <= rx_tmr_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic        tx_busy_q, tx_busy_d;
    logic        tx_q,      tx_d;
    logic [8:0]  tx_fr_q,   tx_fr_d;
    logic [3:0]  tx_cnt_q,  tx_cnt_d;
    logic [15:0] tx_tmr_q,  tx_tmr_d;
    logic        tx_load;
    logic [7:0]  tx_byte;
    logic        tx_end;

    // Last cycle of the stop bit; a load here starts the next frame
    // with no idle gap.
    assign tx_end = tx_busy_q && (tx_cnt_q == 4'd9) && (tx_tmr_q == 16'd0);

    always_comb begin
        tx_busy_d = tx_busy_q;
        tx_d      = tx_q;
        tx_fr_d   = tx_fr_q;
        tx_cnt_d  = tx_cnt_q;
        tx_tmr_d  = tx_tmr_q;
        if (tx_load) begin
            tx_busy_d = 1'b1;
            tx_d      = 1'b0;
            tx_fr_d   = {1'b1, tx_byte};
            tx_cnt_d  = 4'd0;
            tx_tmr_d  = CLK_DIV;
        end else if (tx_busy_q) begin
            if (tx_tmr_q != 16'd0) begin
                tx_tmr_d = tx_tmr_q - 16'd1;
            end else if (tx_cnt_q == 4'd9) begin
                tx_busy_d = 1'b0;
            end else begin
                tx_d     = tx_fr_q[0];
                tx_fr_d  = {1'b1, tx_fr_q[8:1]};
                tx_cnt_d = tx_cnt_q + 4'd1;
                tx_tmr_d = CLK_DIV;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy_q <= 1'b0;
            tx_q      <= 1'b1;
            tx_fr_q   <= 9'h1FF;
            tx_cnt_q  <= 4'd0;
            tx_tmr_q  <= 16'd0;
        end else begin
            tx_busy_q <= tx_busy_d;
            tx_q      <= tx_d;
            tx_fr_q   <= tx_fr_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_tmr_q  <= tx_tmr_d;
        end
    end

    // ------------------------------------------------------------------
    // Command parser and bus initiator
    // ------------------------------------------------------------------
    localparam logic [2:0] P_CMD  = 3'd0;
    localparam logic [2:0] P_ADDR = 3'd1;
    localparam logic [2:0] P_MASK = 3'd2;
    localparam logic [2:0] P_DATA = 3'd3;
    localparam logic [2:0] P_BUS  = 3'd4;
    localparam logic [2:0] P_RESP = 3'd5;

    logic [2:0]  ps_q,    ps_d;
    logic [1:0]  bcnt_q,  bcnt_d;
    logic        rd_q,    rd_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q,  mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  bnext;

    assign bnext = bcnt_q + 2'd1;

    always_comb begin
        ps_d    = ps_q;
        bcnt_d  = bcnt_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        tx_load = 1'b0;
        tx_byte = 8'h00;
        unique case (ps_q)
            P_CMD: begin
                if (rx_valid && rx_sh_q == 8'h01) begin
                    rd_d   = 1'b0;
                    ps_d   = P_ADDR;
                    bcnt_d = 2'd0;
                end else if (rx_valid && rx_sh_q == 8'h02) begin
                    rd_d   = 1'b1;
                    ps_d   = P_ADDR;
                    bcnt_d = 2'd0;
                end
            end
            P_ADDR: begin
                if (rx_ferr) begin
                    ps_d   = P_CMD;
                    bcnt_d = 2'd0;
                end else if (rx_valid) begin
                    addr_d[{bcnt_q, 3'b000} +: 8] = rx_sh_q;
                    bcnt_d = bnext;
                    if (bcnt_q == 2'd3) begin
                        ps_d = rd_q ? P_BUS : P_MASK;
                    end
                end
            end
            P_MASK: begin
                if (rx_ferr) begin
                    ps_d   = P_CMD;
                    bcnt_d = 2'd0;
                end else if (rx_valid) begin
                    mask_d = rx_sh_q[3:0];
                    ps_d   = P_DATA;
                    bcnt_d = 2'd0;
                end
            end
            P_DATA: begin
                if (rx_ferr) begin
                    ps_d   = P_CMD;
                    bcnt_d = 2'd0;
                end else if (rx_valid) begin
                    wdata_d[{bcnt_q, 3'b000} +: 8] = rx_sh_q;
                    bcnt_d = bnext;
                    if (bcnt_q == 2'd3) begin
                        ps_d = P_BUS;
                    end
                end
            end
            P_BUS: begin
                // Transmitter is idle here, so the first response byte
                // can start on the completing cycle.
                if (ready_in) begin
                    ps_d    = P_RESP;
                    bcnt_d  = 2'd0;
                    tx_load = 1'b1;
                    if (rd_q) begin
                        rdata_d = read_value_in;
                        tx_byte = read_value_in[7:0];
                    end else begin
                        tx_byte = 8'hA5;
                    end
                end
            end
            P_RESP: begin
                if (tx_end) begin
                    if (!rd_q || bcnt_q == 2'd3) begin
                        ps_d   = P_CMD;
                        bcnt_d = 2'd0;
                    end else begin
                        bcnt_d  = bnext;
                        tx_load = 1'b1;
                        tx_byte = rdata_q[{bnext, 3'b000} +: 8];
                    end
                end
            end
            default: ps_d = P_CMD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q    <= P_CMD;
            bcnt_q  <= 2'd0;
            rd_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            ps_q    <= ps_d;
            bcnt_q  <= bcnt_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus strobes decode straight from state so reset drops them at once.
    assign sel_out         = (ps_q == P_BUS);
    assign read_out        = sel_out && rd_q;
    assign write_mask_out  = (sel_out && !rd_q) ? mask_q : 4'h0;
    assign address_out     = addr_q;
    assign write_value_out = wdata_q;
    assign tx_out          = tx_q;

endmodule

// File: tb/tb_uart_bridge.sv
// Directed bench for uart_bridge with CLK_DIV=3 (4-cycle bit time).
// Drives serial commands, models a bus responder, decodes tx frames.

module tb_uart_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_in;
    logic        tx_out;
    logic        sel_out;
    logic        read_out;
    logic [3:0]  write_mask_out;
    logic [31:0] address_out;
    logic [31:0] write_value_out;
    logic [31:0] read_value_in;
    logic        ready_in = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_bridge #(.CLK_DIV(16'd3)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_in          (rx_in),
        .tx_out         (tx_out),
        .sel_out        (sel_out),
        .read_out       (read_out),
        .write_mask_out (write_mask_out),
        .address_out    (address_out),
        .write_value_out(write_value_out),
        .read_value_in  (read_value_in),
        .ready_in       (ready_in)
    );

    // Bus responder: ready after rsp_wait cycles of sel_out.
    int          rsp_wait   = 0;
    int          cur_len    = 0;
    int          sel_len    = 0;
    int          sel_starts = 0;
    logic        sel_prev   = 1'b0;
    logic [31:0] s_addr     = '0;
    logic [31:0] s_wdata    = '0;
    logic [3:0]  s_mask     = '0;
    logic        s_read     = 1'b0;

    always @(negedge clk) begin
        if (sel_out === 1'b1) begin
            if (!sel_prev) begin
                sel_starts = sel_starts + 1;
                cur_len = 1;
            end else begin
                cur_len = cur_len + 1;
            end
            sel_len  = cur_len;
            s_addr   = address_out;
            s_wdata  = write_value_out;
            s_mask   = write_mask_out;
            s_read   = read_out;
            ready_in = (cur_len > rsp_wait);
        end else begin
            ready_in = 1'b0;
        end
        sel_prev = (sel_out === 1'b1);
    end

    // Serial response decoder: {stop, data} per frame plus start time.
    logic [8:0] txq[$];
    time        tst[$];

    always @(negedge tx_out) begin
        logic [8:0] f;
        if (reset === 1'b0) begin
            tst.push_back($time);
            #15;
            for (int i = 0; i < 9; i++) begin
                #40;
                f[i] = tx_out;
            end
            txq.push_back(f);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tx_at(input int i);
        return (i < txq.size()) ? {23'd0, txq[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] gap(input int i);
        return (i + 1 < tst.size()) ? 32'(tst[i+1] - tst[i]) : 32'd0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (4) @(negedge clk);
        end
        rx_in = stop;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (txq.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        check("tx_frames", txq.size(), n);
    endtask

    task automatic clear_obs();
        txq.delete();
        tst.delete();
    endtask

    int base;

    initial begin
        reset = 1'b1;
        rx_in = 1'b1;
        read_value_in = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_out, 1);
        check("rst_sel", sel_out, 0);
        check("rst_read", read_out, 0);
        check("rst_mask", write_mask_out, 0);
        check("rst_addr", address_out, 0);
        check("rst_wdata", write_value_out, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Read with two wait cycles.
        clear_obs();
        rsp_wait = 2;
        read_value_in = 32'hDEADBEEF;
        base = sel_starts;
        send_read(32'h0000_0010);
        wait_tx(4);
        check("rd_txn", sel_starts - base, 1);
        check("rd_sel_len", sel_len, 3);
        check("rd_addr", s_addr, 32'h10);
        check("rd_strobe", s_read, 1);
        check("rd_mask", s_mask, 0);
        check("rd_b0", tx_at(0), 32'h1EF);
        check("rd_b1", tx_at(1), 32'h1BE);
        check("rd_b2", tx_at(2), 32'h1AD);
        check("rd_b3", tx_at(3), 32'h1DE);
        check("rd_gap0", gap(0), 400);
        check("rd_gap2", gap(2), 400);
        check("rd_sel_idle", sel_out, 0);

        // Write, immediate ready.
        clear_obs();
        rsp_wait = 0;
        base = sel_starts;
        send_byte(8'h01, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h80, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        wait_tx(1);
        check("wr_txn", sel_starts - base, 1);
        check("wr_sel_len", sel_len, 1);
        check("wr_mask", s_mask, 4'b0011);
        check("wr_addr", s_addr, 32'h8000_0004);
        check("wr_wdata", s_wdata, 32'h4433_2211);
        check("wr_strobe", s_read, 0);
        check("wr_resp", tx_at(0), 32'h1A5);
        check("wr_mask_idle", write_mask_out, 0);

        // Unknown command byte ignored.
        clear_obs();
        read_value_in = 32'h0BAD_F00D;
        base = sel_starts;
        send_byte(8'h7F, 1'b1);
        send_read(32'h0);
        wait_tx(4);
        check("bad_txn", sel_starts - base, 1);
        check("bad_addr", s_addr, 32'h0);
        check("bad_strobe", s_read, 1);
        check("bad_b0", tx_at(0), 32'h10D);
        check("bad_b3", tx_at(3), 32'h10B);

        // Framing error returns parser to command state.
        clear_obs();
        read_value_in = 32'h1234_5678;
        base = sel_starts;
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (8) @(negedge clk);
        check("fe_no_bus", sel_starts - base, 0);
        send_read(32'h0);
        wait_tx(4);
        check("fe_txn", sel_starts - base, 1);
        check("fe_addr", s_addr, 32'h0);
        check("fe_strobe", s_read, 1);
        check("fe_b1", tx_at(1), 32'h156);

        // Half-bit glitches: one in command state, one inside address.
        clear_obs();
        read_value_in = 32'h0000_00C3;
        base = sel_starts;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        check("gl_no_bus", sel_starts - base, 0);
        check("gl_no_tx", txq.size(), 0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h10, 1'b1);
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_tx(4);
        check("gl_txn", sel_starts - base, 1);
        check("gl_addr", s_addr, 32'h10);
        check("gl_b0", tx_at(0), 32'h1C3);

        // Reset while the responder holds the bus waiting.
        clear_obs();
        rsp_wait = 1000;
        send_read(32'h0000_0020);
        begin
            int k = 0;
            while (sel_out !== 1'b1 && k < 500) begin
                @(negedge clk);
                k++;
            end
        end
        check("rb_sel_up", sel_out, 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rb_sel", sel_out, 0);
        check("rb_read", read_out, 0);
        check("rb_tx", tx_out, 1);
        check("rb_addr", address_out, 0);
        @(negedge clk);
        reset = 1'b0;
        rsp_wait = 2;
        read_value_in = 32'hCAFE_F00D;
        base = sel_starts;
        repeat (2) @(negedge clk);
        send_read(32'h0000_0030);
        wait_tx(4);
        check("rb_txn", sel_starts - base, 1);
        check("rb_addr2", s_addr, 32'h30);
        check("rb_b0", tx_at(0), 32'h10D);
        check("rb_b3", tx_at(3), 32'h1CA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_bridge.md
UART_BRIDGE -- requirements
Module: uart_bridge

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16'd103, meaning one serial bit time = CLK_DIV+1 clk cycles.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_in  input  1  serial command input, 8N1, idle high.
REQ-005 SHALL have port tx_out  output  1  serial response output, 8N1, idle high.
REQ-006 SHALL have port sel_out  output  1  bus transaction request (initiator side).
REQ-007 SHALL have port read_out  output  1  bus read strobe, valid with sel_out.
REQ-008 SHALL have port write_mask_out  output  4  bus byte-write enables, valid with sel_out.
REQ-009 SHALL have port address_out  output  32  bus byte address.
REQ-010 SHALL have port write_value_out  output  32  bus write data.
REQ-011 SHALL have port read_value_in  input  32  bus read data, sampled when ready_in high.
REQ-012 SHALL have port ready_in  input  1  responder completes transaction in the cycle it is high with sel_out.

Function
REQ-013 SHALL pass rx_in through a 2-flop synchroniser before any use.
REQ-014 RX: on synchronised falling edge while idle, wait CLK_DIV/2 cycles (floor), re-check low (high -> abort, back to idle), then sample 8 data bits LSB-first and stop bit, each CLK_DIV+1 cycles apart.
REQ-015 RX: stop bit 0 = framing error -> byte discarded and parser forced to CMD.
REQ-016 TX: frame = start 0, 8 data LSB-first, stop 1, each bit held exactly CLK_DIV+1 cycles; back-to-back bytes with no idle gap.
REQ-017 Parser states CMD, ADDR, MASK, DATA, BUS, RESP; 2-bit byte counter in ADDR/DATA/RESP.
REQ-018 CMD: byte 0x01 -> write, 0x02 -> read, enter ADDR, counter 0; any other byte ignored, stay CMD.
REQ-019 ADDR: 4 bytes little-endian into address_out[8k+7:8k]; after 4th byte: write -> MASK, read -> BUS.
REQ-020 MASK: write_mask register := byte[3:0] (byte[7:4] ignored) -> DATA.
REQ-021 DATA: 4 bytes little-endian into write_value_out -> BUS after 4th.
REQ-022 BUS: sel_out=1; read: read_out=1, write_mask_out=0; write: read_out=0, write_mask_out=mask register; address_out/write_value_out stable throughout.
REQ-023 BUS: held for any number of cycles until ready_in=1; that cycle captures read_value_in (read); next cycle sel_out=read_out=0, write_mask_out=0, state RESP.
REQ-024 Write with mask 0 SHALL still perform the BUS handshake.
REQ-025 RESP: write -> transmit 0xA5; read -> transmit captured data, 4 bytes LSB byte first; -> CMD after last stop bit completes.
REQ-026 Bytes completing reception during BUS or RESP SHALL be discarded.
REQ-027 At most one bus transaction outstanding; sel_out never asserted outside BUS.
REQ-028 All counters unsigned; bit-timer reload CLK_DIV, decrement to 0 (no wrap); byte counter wraps 3 -> 0 only on state exit.

Reset
REQ-029 Reset asserted: tx_out=1, sel_out=0, read_out=0, write_mask_out=0, address_out=0, write_value_out=0, parser CMD, RX/TX idle, synchroniser = 1.
REQ-030 Reset mid-frame or mid-BUS SHALL abort immediately (asynchronously); in-flight transaction and partial bytes lost; no glitch on tx_out other than forcing 1.
REQ-031 After reset deassertion, first valid start bit SHALL be accepted without extra delay beyond synchroniser latency.

Verification (CLK_DIV=3)
REQ-032 Bench: send 02 10 00 00 00, responder ready_in=1 after 2 wait cycles, read_value_in=0xDEADBEEF -> address_out=0x00000010, sel_out/read_out high 3 cycles, tx bytes EF BE AD DE.
REQ-033 Bench: send 01 04 00 00 80 03 11 22 33 44, ready_in tied 1 -> one cycle sel_out=1, write_mask_out=4'b0011, address_out=0x80000004, write_value_out=0x44332211, tx 0xA5.
REQ-034 Bench: send 0x7F then 02 00 00 00 00 -> 0x7F ignored, read of address 0 performed normally.
REQ-035 Bench: send 01 then byte with stop bit 0 -> no bus activity; following 02 00 00 00 00 executes as read.
REQ-036 Bench: 0.5-bit low glitch on rx_in -> no byte received, parser stays CMD.
REQ-037 Bench: reset pulse during BUS wait -> sel_out=0 and tx_out=1 same cycle, then full read command succeeds.
